// File: rtl/gen_scheduler_pkg.sv
// Shared type definitions for the Game of Life core.
// The generation scheduler state encoding lives here so debug tooling can decode o_state.
package defs;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_WAIT,
        SCHED_LAUNCH,
        SCHED_BUSY
    } sched_state_t;

endpackage

// File: rtl/gen_scheduler.sv
// Generation scheduler: issues one-cycle go pulses to next_field_iter and tracks completion.
// Supports run/pause, single-step, a start-to-start period and optional frame-start alignment.
module gen_scheduler
    import defs::*;
#(
    parameter int PERIOD_W   = 24,
    parameter int GEN_CNT_W  = 16,
    parameter bit SYNC_FRAME = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic [PERIOD_W-1:0]  i_period,
    input  logic                 i_frame_start,
    input  logic                 i_clear_cnt,
    input  logic                 i_is_simulating,
    output logic                 o_go,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [GEN_CNT_W-1:0] o_gen_cnt,
    output logic [1:0]           o_state
);

    sched_state_t         state;
    sched_state_t         next_state;
    logic [PERIOD_W-1:0]  period_cnt;
    logic [PERIOD_W-1:0]  period_cnt_next;
    logic [PERIOD_W-1:0]  period_tgt;
    logic                 step_pend;
    logic                 step_pend_next;
    logic                 seen_sim;
    logic                 seen_sim_next;
    logic                 eligible;
    logic                 step_live;
    logic                 step_seen;
    logic                 period_met;
    logic                 done_event;
    logic                 done_q;
    logic [GEN_CNT_W-1:0] gen_cnt;

    always_comb begin
        eligible   = !SYNC_FRAME || i_frame_start;
        step_live  = i_step && !i_run;
        step_seen  = step_live || step_pend;
        period_tgt = (i_period == '0) ? {{(PERIOD_W-1){1'b0}}, 1'b1} : i_period;
        period_met = (period_cnt >= period_tgt);
        done_event = (state == SCHED_BUSY) && seen_sim && !i_is_simulating;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            SCHED_IDLE: begin
                if (step_seen && eligible) begin
                    next_state = SCHED_LAUNCH;
                end else if (i_run) begin
                    next_state = SCHED_WAIT;
                end
            end
            SCHED_WAIT: begin
                if (!i_run) begin
                    next_state = SCHED_IDLE;
                end else if (period_met && eligible) begin
                    next_state = SCHED_LAUNCH;
                end
            end
            SCHED_LAUNCH: begin
                next_state = SCHED_BUSY;
            end
            SCHED_BUSY: begin
                if (done_event) begin
                    next_state = i_run ? SCHED_WAIT : SCHED_IDLE;
                end
            end
            default: begin
                next_state = SCHED_IDLE;
            end
        endcase
    end

    // The counter reads k+1 k cycles after a launch, so a launch lands exactly i_period after the previous one.
    always_comb begin
        period_cnt_next = period_cnt;
        if (next_state == SCHED_LAUNCH && state != SCHED_LAUNCH) begin
            period_cnt_next = {{(PERIOD_W-1){1'b0}}, 1'b1};
        end else if (next_state == SCHED_IDLE) begin
            period_cnt_next = '0;
        end else if (period_cnt != '1) begin
            period_cnt_next = period_cnt + {{(PERIOD_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        step_pend_next = step_pend;
        if (state == SCHED_LAUNCH) begin
            step_pend_next = 1'b0;
        end else if (step_live && ((state == SCHED_IDLE && !eligible) || state == SCHED_BUSY)) begin
            step_pend_next = 1'b1;
        end
        seen_sim_next = (state == SCHED_BUSY) && !done_event && (seen_sim || i_is_simulating);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCHED_IDLE;
            period_cnt <= '0;
            step_pend  <= 1'b0;
            seen_sim   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= next_state;
            period_cnt <= period_cnt_next;
            step_pend  <= step_pend_next;
            seen_sim   <= seen_sim_next;
            done_q     <= done_event;
        end
    end

    // A clear coinciding with a completion wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_cnt <= '0;
        end else if (i_clear_cnt) begin
            gen_cnt <= '0;
        end else if (done_event) begin
            gen_cnt <= gen_cnt + {{(GEN_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_go      = (state == SCHED_LAUNCH);
    assign o_busy    = (state == SCHED_LAUNCH) || (state == SCHED_BUSY);
    assign o_done    = done_q;
    assign o_gen_cnt = gen_cnt;
    assign o_state   = state;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler with one unsynchronised (dut0) and one frame-synchronised (dut1) instance.
// A small iterator model holds is_simulating high for 14 cycles after each go, so a generation spans 15 cycles.
module tb_gen_scheduler;
    import defs::*;

    localparam int PERIOD_W  = 24;
    localparam int GEN_CNT_W = 16;
    localparam int SIM_LEN   = 14;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 run;
    logic                 step;
    logic [PERIOD_W-1:0]  period;
    logic                 frame_start;
    logic                 clear_cnt;

    logic                 sim0, sim1;
    logic                 go0, busy0, done0;
    logic                 go1, busy1, done1;
    logic [GEN_CNT_W-1:0] cnt0, cnt1;
    logic [1:0]           state0, state1;
    int                   sim_left0, sim_left1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Iterator models: is_simulating rises at the edge after go and stays high SIM_LEN cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sim_left0 <= 0;
        else if (go0) sim_left0 <= SIM_LEN;
        else if (sim_left0 > 0) sim_left0 <= sim_left0 - 1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sim_left1 <= 0;
        else if (go1) sim_left1 <= SIM_LEN;
        else if (sim_left1 > 0) sim_left1 <= sim_left1 - 1;
    end
    assign sim0 = (sim_left0 != 0);
    assign sim1 = (sim_left1 != 0);

    gen_scheduler #(.PERIOD_W(PERIOD_W), .GEN_CNT_W(GEN_CNT_W), .SYNC_FRAME(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_run(run), .i_step(step), .i_period(period),
        .i_frame_start(frame_start), .i_clear_cnt(clear_cnt), .i_is_simulating(sim0),
        .o_go(go0), .o_busy(busy0), .o_done(done0), .o_gen_cnt(cnt0), .o_state(state0)
    );

    gen_scheduler #(.PERIOD_W(PERIOD_W), .GEN_CNT_W(GEN_CNT_W), .SYNC_FRAME(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_run(run), .i_step(step), .i_period(period),
        .i_frame_start(frame_start), .i_clear_cnt(clear_cnt), .i_is_simulating(sim1),
        .o_go(go1), .o_busy(busy1), .o_done(done1), .o_gen_cnt(cnt1), .o_state(state1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        run         = 1'b0;
        step        = 1'b0;
        frame_start = 1'b0;
        clear_cnt   = 1'b0;
        period      = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        run         = 1'b0;
        step        = 1'b0;
        frame_start = 1'b0;
        clear_cnt   = 1'b0;
        period      = '0;
        #2;
        checks++;
        if ({go0, busy0, done0} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags0: got go/busy/done=%b expected 000", {go0, busy0, done0});
        end
        checks++;
        if (cnt0 !== 16'd0 || state0 !== SCHED_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_cnt_state0: got cnt=%0d state=%0d expected cnt=0 state=0", cnt0, state0);
        end
        checks++;
        if ({go1, busy1, done1} !== 3'b000 || cnt1 !== 16'd0 || state1 !== SCHED_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got go/busy/done=%b cnt=%0d state=%0d expected 000 0 0",
                     {go1, busy1, done1}, cnt1, state1);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_step();
        int go_n;
        int done_n;
        int done_at;
        go_n    = 0;
        done_n  = 0;
        done_at = -1;
        apply_reset();
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (go0 !== 1'b1 || state0 !== SCHED_LAUNCH) begin
            errors++;
            $display("[TB] FAIL step_latency: got go=%b state=%0d expected go=1 state=2", go0, state0);
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (go0) go_n++;
            if (done0) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
        end
        checks++;
        if (go_n !== 0) begin
            errors++;
            $display("[TB] FAIL step_extra_go: got %0d further go pulses expected 0", go_n);
        end
        checks++;
        if (done_n !== 1 || done_at !== 16) begin
            errors++;
            $display("[TB] FAIL step_done: got %0d pulses first at +%0d expected 1 at +16", done_n, done_at);
        end
        checks++;
        if (cnt0 !== 16'd1 || state0 !== SCHED_IDLE || busy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step_final: got cnt=%0d state=%0d busy=%b expected 1 0 0", cnt0, state0, busy0);
        end
    endtask

    task automatic test_spacing(input int per, input int gap, input int nlaunch, input int final_cnt);
        int launches[8];
        int n;
        int cyc;
        int viol;
        logic [1:0] prev_state;
        n    = 0;
        cyc  = 0;
        viol = 0;
        apply_reset();
        period = PERIOD_W'(per);
        run    = 1'b1;
        prev_state = state0;
        while (n < nlaunch && cyc < 600) begin
            tick();
            cyc++;
            if (go0) begin
                if (prev_state == SCHED_BUSY || prev_state == SCHED_LAUNCH) viol++;
                launches[n] = cyc;
                n++;
            end
            prev_state = state0;
        end
        run = 1'b0;
        checks++;
        if (n !== nlaunch) begin
            errors++;
            $display("[TB] FAIL spacing_p%0d_count: got %0d launches expected %0d", per, n, nlaunch);
        end
        for (int i = 1; i < n; i++) begin
            checks++;
            if (launches[i] - launches[i-1] !== gap) begin
                errors++;
                $display("[TB] FAIL spacing_p%0d_gap%0d: got %0d cycles expected %0d",
                         per, i, launches[i] - launches[i-1], gap);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("[TB] FAIL spacing_p%0d_overlap: got %0d go pulses during busy expected 0", per, viol);
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            if (state0 == SCHED_IDLE) break;
        end
        checks++;
        if (state0 !== SCHED_IDLE || cnt0 !== GEN_CNT_W'(final_cnt)) begin
            errors++;
            $display("[TB] FAIL spacing_p%0d_final: got state=%0d cnt=%0d expected 0 %0d",
                     per, state0, cnt0, final_cnt);
        end
    endtask

    task automatic test_sync_step();
        int go_at[4];
        int go_n;
        go_n = 0;
        apply_reset();
        for (int c = 0; c < 240; c++) begin
            if (go1) begin
                if (go_n < 4) go_at[go_n] = c;
                go_n++;
            end
            frame_start = (c == 100 || c == 200);
            step        = (c == 10 || c == 105 || c == 110);
            tick();
        end
        frame_start = 1'b0;
        step        = 1'b0;
        checks++;
        if (go_n !== 2) begin
            errors++;
            $display("[TB] FAIL sync_go_count: got %0d launches expected 2", go_n);
        end
        if (go_n >= 2) begin
            checks++;
            if (go_at[0] !== 101 || go_at[1] !== 201) begin
                errors++;
                $display("[TB] FAIL sync_go_cycles: got %0d,%0d expected 101,201", go_at[0], go_at[1]);
            end
        end
        checks++;
        if (cnt1 !== 16'd2 || state1 !== SCHED_IDLE) begin
            errors++;
            $display("[TB] FAIL sync_final: got cnt=%0d state=%0d expected 2 0", cnt1, state1);
        end
    endtask

    task automatic test_run_drop_clear();
        bit found;
        found = 1'b0;
        apply_reset();
        period = PERIOD_W'(3);
        run    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (go0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL drop_launch: got no go within 50 cycles expected one");
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) begin
                checks++;
                if (busy0 !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL drop_not_aborted: got busy=%b expected 1", busy0);
                end
            end
            if (k == 16) begin
                checks++;
                if (done0 !== 1'b1 || state0 !== SCHED_IDLE) begin
                    errors++;
                    $display("[TB] FAIL drop_done: got done=%b state=%0d expected 1 0", done0, state0);
                end
                checks++;
                if (cnt0 !== 16'd0) begin
                    errors++;
                    $display("[TB] FAIL clear_wins: got cnt=%0d expected 0", cnt0);
                end
            end
            if (k == 3) run = 1'b0;
            clear_cnt = (k == 15);
        end
        clear_cnt = 1'b0;
    endtask

    task automatic test_async_reset();
        int go_n;
        bit resumed;
        go_n    = 0;
        resumed = 1'b0;
        apply_reset();
        period = PERIOD_W'(3);
        run    = 1'b1;
        for (int i = 0; i < 100 && go_n < 2; i++) begin
            tick();
            if (go0) go_n++;
        end
        repeat (5) tick();
        checks++;
        if (cnt0 !== 16'd1 || busy0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_pre: got cnt=%0d busy=%b expected 1 1", cnt0, busy0);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({go0, busy0, done0} !== 3'b000 || state0 !== SCHED_IDLE) begin
            errors++;
            $display("[TB] FAIL areset_flags: got go/busy/done=%b state=%0d expected 000 0",
                     {go0, busy0, done0}, state0);
        end
        checks++;
        if (cnt0 !== 16'd0) begin
            errors++;
            $display("[TB] FAIL areset_cnt: got cnt=%0d expected 0", cnt0);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (go0) begin
                resumed = 1'b1;
                break;
            end
        end
        checks++;
        if (!resumed) begin
            errors++;
            $display("[TB] FAIL areset_resume: got no go within 40 cycles expected one");
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_spacing(40, 40, 5, 5);
        test_spacing(3, 17, 4, 4);
        test_spacing(0, 17, 4, 4);
        test_sync_step();
        test_run_drop_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
